// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit producing HI/LO for MULT, MULTU, DIV and DIVU.
// One radix-2 shift-add / restoring-divide step per cycle over a shared
// accumulator (acc_hi:acc_lo) and operand register (mcand).
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t             state;
    logic               op_div;
    logic               op_signed;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   a_raw;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [CW-1:0]      count;

    logic               start_signed;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_borrow;
    logic [WIDTH-1:0]   step_hi;
    logic [WIDTH-1:0]   step_lo;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   fin_hi;
    logic [WIDTH-1:0]   fin_lo;
    logic               fin_dbz;

    // Operand magnitudes for signed ops; unsigned ops pass raw values through
    always_comb begin
        start_signed = ~op[0];
        a_abs        = (start_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
        b_abs        = (start_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
    end

    // One iteration: shift-add for multiply, shift/trial-subtract for divide
    always_comb begin
        mul_sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
        div_shift  = {acc_hi, acc_lo[WIDTH-1]};
        div_diff   = div_shift - {1'b0, mcand};
        div_borrow = (div_shift < {1'b0, mcand});
        if (op_div) begin
            step_hi = div_borrow ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], ~div_borrow};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    // Final result with sign correction and divide-by-zero override
    always_comb begin
        product = {step_hi, step_lo};
        fin_hi  = step_hi;
        fin_lo  = step_lo;
        fin_dbz = 1'b0;
        if (op_div) begin
            if (mcand == '0) begin
                fin_lo  = '1;
                fin_hi  = a_raw;
                fin_dbz = 1'b1;
            end else begin
                if (op_signed && (sign_a ^ sign_b)) fin_lo = ~step_lo + 1'b1;
                if (op_signed && sign_a)            fin_hi = ~step_hi + 1'b1;
            end
        end else if (op_signed && (sign_a ^ sign_b)) begin
            {fin_hi, fin_lo} = ~product + 1'b1;
        end
    end

    // Control FSM and datapath registers; results land on the last RUN edge
    // so that hi/lo are valid in the same cycle done is high
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            op_div      <= 1'b0;
            op_signed   <= 1'b0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            a_raw       <= '0;
            mcand       <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            count       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_div    <= op[1];
                        op_signed <= start_signed;
                        sign_a    <= start_signed & a[WIDTH-1];
                        sign_b    <= start_signed & b[WIDTH-1];
                        a_raw     <= a;
                        acc_hi    <= '0;
                        if (op[1]) begin
                            acc_lo <= a_abs;
                            mcand  <= b_abs;
                        end else begin
                            acc_lo <= b_abs;
                            mcand  <= a_abs;
                        end
                        count <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    if (count == CW'(WIDTH - 1)) begin
                        count       <= '0;
                        hi          <= fin_hi;
                        lo          <= fin_lo;
                        div_by_zero <= fin_dbz;
                        done        <= 1'b1;
                        state       <= FINISH;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                FINISH: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed testbench for mul_div_unit with hand-computed expected results.
module tb_mul_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    int errors;
    int checks;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    // Free-running clock, 10 ns period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time limit so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive one start pulse sampled at the next rising edge, then scramble operands
    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = ~x;
        b     = ~y;
    endtask

    // Count cycles after launch until done, noting whether busy ever dropped
    task automatic wait_done(output int cyc, output bit busy_ok);
        cyc     = -1;
        busy_ok = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                cyc = c;
                break;
            end
        end
    endtask

    // Reset state of every output
    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (hi !== 32'h0) begin errors++; $display("[TB] FAIL reset_hi: got %h expected 0", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("[TB] FAIL reset_lo: got %h expected 0", lo); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("[TB] FAIL reset_dbz: got %b expected 0", div_by_zero); end
        rst = 1'b0;
    endtask

    // MULTU of the largest operands, with latency and busy window
    task automatic test_multu_max;
        int cyc;
        bit bok;
        launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(cyc, bok);
        checks++; if (cyc !== 33) begin errors++; $display("[TB] FAIL multu_latency: got %0d expected 33", cyc); end
        checks++; if (bok !== 1'b1) begin errors++; $display("[TB] FAIL multu_busy: busy dropped before done"); end
        checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("[TB] FAIL multu_hi: got %h expected fffffffe", hi); end
        checks++; if (lo !== 32'h0000_0001) begin errors++; $display("[TB] FAIL multu_lo: got %h expected 00000001", lo); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("[TB] FAIL multu_dbz: got %b expected 0", div_by_zero); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL multu_done_pulse: got %b expected 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL multu_busy_after: got %b expected 0", busy); end
        checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("[TB] FAIL multu_hi_hold: got %h expected fffffffe", hi); end
    endtask

    // Signed multiply with negative operand, then an unsigned divide
    task automatic test_mult_signed_divu;
        int cyc;
        bit bok;
        launch(OP_MULT, 32'hFFFF_FFFD, 32'd5);
        wait_done(cyc, bok);
        checks++; if (cyc !== 33) begin errors++; $display("[TB] FAIL mult_latency: got %0d expected 33", cyc); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL mult_hi: got %h expected ffffffff", hi); end
        checks++; if (lo !== 32'hFFFF_FFF1) begin errors++; $display("[TB] FAIL mult_lo: got %h expected fffffff1", lo); end
        launch(OP_DIVU, 32'd100, 32'd7);
        wait_done(cyc, bok);
        checks++; if (cyc !== 33) begin errors++; $display("[TB] FAIL divu_latency: got %0d expected 33", cyc); end
        checks++; if (lo !== 32'd14) begin errors++; $display("[TB] FAIL divu_lo: got %h expected 0000000e", lo); end
        checks++; if (hi !== 32'd2) begin errors++; $display("[TB] FAIL divu_hi: got %h expected 00000002", hi); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("[TB] FAIL divu_dbz: got %b expected 0", div_by_zero); end
    endtask

    // Signed divide sign correction and the overflow corner
    task automatic test_div_signed;
        int cyc;
        bit bok;
        launch(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(cyc, bok);
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("[TB] FAIL div_neg_lo: got %h expected fffffffd", lo); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL div_neg_hi: got %h expected ffffffff", hi); end
        launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(cyc, bok);
        checks++; if (cyc !== 33) begin errors++; $display("[TB] FAIL div_ovf_latency: got %0d expected 33", cyc); end
        checks++; if (lo !== 32'h8000_0000) begin errors++; $display("[TB] FAIL div_ovf_lo: got %h expected 80000000", lo); end
        checks++; if (hi !== 32'h0) begin errors++; $display("[TB] FAIL div_ovf_hi: got %h expected 00000000", hi); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("[TB] FAIL div_ovf_dbz: got %b expected 0", div_by_zero); end
    endtask

    // Divide by zero flags and fixed results
    task automatic test_div_by_zero;
        int cyc;
        bit bok;
        launch(OP_DIVU, 32'h1234_5678, 32'h0);
        wait_done(cyc, bok);
        checks++; if (cyc !== 33) begin errors++; $display("[TB] FAIL dbz_latency: got %0d expected 33", cyc); end
        checks++; if (div_by_zero !== 1'b1) begin errors++; $display("[TB] FAIL dbz_flag: got %b expected 1", div_by_zero); end
        checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL dbz_lo: got %h expected ffffffff", lo); end
        checks++; if (hi !== 32'h1234_5678) begin errors++; $display("[TB] FAIL dbz_hi: got %h expected 12345678", hi); end
    endtask

    // Starts during RUN and FINISH are ignored; the next IDLE start is taken
    task automatic test_back_to_back;
        int          dcount;
        int          dcyc;
        logic [31:0] cap_hi;
        logic [31:0] cap_lo;
        int          cyc;
        bit          bok;
        dcount = 0;
        dcyc   = -1;
        cap_hi = 32'hX;
        cap_lo = 32'hX;
        launch(OP_MULTU, 32'd6, 32'd7);
        for (int c = 1; c <= 33; c++) begin
            @(negedge clk);
            if (done) begin
                dcount++;
                dcyc   = c;
                cap_hi = hi;
                cap_lo = lo;
            end
            if (c == 5 || c == 33) begin
                op    = OP_DIVU;
                a     = 32'd9;
                b     = 32'd9;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        checks++; if (dcount !== 1) begin errors++; $display("[TB] FAIL ignore_done_count: got %0d expected 1", dcount); end
        checks++; if (dcyc !== 33) begin errors++; $display("[TB] FAIL ignore_latency: got %0d expected 33", dcyc); end
        checks++; if (cap_lo !== 32'd42) begin errors++; $display("[TB] FAIL ignore_lo: got %h expected 0000002a", cap_lo); end
        checks++; if (cap_hi !== 32'd0) begin errors++; $display("[TB] FAIL ignore_hi: got %h expected 00000000", cap_hi); end
        launch(OP_MULTU, 32'd3, 32'd4);
        wait_done(cyc, bok);
        checks++; if (cyc !== 33) begin errors++; $display("[TB] FAIL b2b_latency: got %0d expected 33", cyc); end
        checks++; if (lo !== 32'd12) begin errors++; $display("[TB] FAIL b2b_lo: got %h expected 0000000c", lo); end
        checks++; if (hi !== 32'd0) begin errors++; $display("[TB] FAIL b2b_hi: got %h expected 00000000", hi); end
    endtask

    // Reset in the middle of a divide discards it; a later op runs normally
    task automatic test_reset_mid;
        int dcount;
        int cyc;
        bit bok;
        dcount = 0;
        launch(OP_DIV, 32'd1000, 32'd3);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL midrst_done: got %b expected 0", done); end
        checks++; if (hi !== 32'h0) begin errors++; $display("[TB] FAIL midrst_hi: got %h expected 0", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("[TB] FAIL midrst_lo: got %h expected 0", lo); end
        rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        checks++; if (dcount !== 0) begin errors++; $display("[TB] FAIL midrst_no_done: got %0d pulses expected 0", dcount); end
        launch(OP_MULTU, 32'd2, 32'd3);
        wait_done(cyc, bok);
        checks++; if (cyc !== 33) begin errors++; $display("[TB] FAIL midrst_next_latency: got %0d expected 33", cyc); end
        checks++; if (lo !== 32'd6) begin errors++; $display("[TB] FAIL midrst_next_lo: got %h expected 00000006", lo); end
    endtask

    // Scenario sequence
    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        start  = 1'b0;
        op     = 2'b00;
        a      = 32'h0;
        b      = 32'h0;
        test_reset;
        test_multu_max;
        test_mult_signed_divu;
        test_div_signed;
        test_div_by_zero;
        test_back_to_back;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
